// File: rtl/tick_timer_ctrl.sv
`timescale 1ns/1ps
// tick_timer_ctrl: prescaled interval timer with one-shot and periodic expiry.
// Define TICK_TIMER_CTRL_PAUSE_EN to add a pause input that freezes counting in RUN.
module tick_timer_ctrl #(
  parameter int unsigned M = 10,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic [W-1:0] period,
`ifdef TICK_TIMER_CTRL_PAUSE_EN
  input  logic         pause,
`endif
  output logic         busy,
  output logic         pre_tick,
  output logic         done_tick,
  output logic [W-1:0] remaining
);

  localparam int unsigned PW = (M > 2) ? $clog2(M) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(M - 1);
  localparam logic [W-1:0]  ONE      = W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic [W-1:0]   per_reg;
  logic           mode_reg;
  logic           hold;

`ifdef TICK_TIMER_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign busy      = (state == RUN);
  assign pre_tick  = (state == RUN) && !hold && (presc == PRE_LAST);
  assign done_tick = pre_tick && (remaining == ONE);

  // Stop (or a zero-period start) beats restart, which beats expiry/reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      per_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop && (period != '0)) begin
            state     <= RUN;
            per_reg   <= period;
            mode_reg  <= oneshot;
            remaining <= period;
            presc     <= '0;
          end
        end
        RUN: begin
          if (stop || (start && (period == '0))) begin
            state     <= IDLE;
            remaining <= '0;
            presc     <= '0;
          end else if (start) begin
            per_reg   <= period;
            mode_reg  <= oneshot;
            remaining <= period;
            presc     <= '0;
          end else if (!hold) begin
            presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
            if (pre_tick) begin
              if (remaining > ONE) begin
                remaining <= remaining - ONE;
              end else if (mode_reg) begin
                state     <= IDLE;
                remaining <= '0;
              end else begin
                remaining <= per_reg;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
`timescale 1ns/1ps
// Bench for tick_timer_ctrl: vector table, directed corner sequences and a
// randomized run checked against an arithmetic elapsed-cycle model.
module tb_tick_timer_ctrl;

  localparam int M = 10;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic [7:0] period;
  logic       pause;
  logic       busy;
  logic       pre_tick;
  logic       done_tick;
  logic [7:0] remaining;

  tick_timer_ctrl #(.M(M), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .period    (period),
`ifdef TICK_TIMER_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .busy      (busy),
    .pre_tick  (pre_tick),
    .done_tick (done_tick),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: elapsed counted cycles since the last (re)start
  bit m_active;
  int m_c;
  int m_p;
  bit m_mode;

  logic       last_busy, last_pre, last_done;
  logic [7:0] last_rem;
  int         dones_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_c = 0; m_p = 0; m_mode = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic s, input logic sp, input logic os,
                       input logic [7:0] per, input logic pa);
    logic ep;
    logic e_busy, e_pre, e_done;
    int   e_rem, mp;
`ifdef TICK_TIMER_CTRL_PAUSE_EN
    ep = pa;
`else
    ep = 1'b0;
`endif
    @(negedge clk);
    start = s; stop = sp; oneshot = os; period = per; pause = ep;
    #1;
    mp     = M * m_p;
    e_busy = m_active;
    e_pre  = m_active && !ep && ((m_c % M) == M - 1);
    e_rem  = m_active ? (m_p - (m_c % mp) / M) : 0;
    e_done = e_pre && ((m_c % mp) == mp - 1);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pre_tick", 32'(pre_tick), 32'(e_pre));
    chk("done_tick", 32'(done_tick), 32'(e_done));
    chk("remaining", 32'(remaining), 32'(e_rem));
    last_busy = busy; last_pre = pre_tick; last_done = done_tick; last_rem = remaining;
    if (done_tick === 1'b1) dones_seen++;
    if (m_active) begin
      if (sp || (s && per == 0)) m_active = 0;
      else if (s) begin m_c = 0; m_p = int'(per); m_mode = os; end
      else if (!ep) begin
        if (e_done && m_mode) m_active = 0;
        m_c++;
      end
    end else if (s && !sp && per != 0) begin
      m_active = 1; m_c = 0; m_p = int'(per); m_mode = os;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  typedef struct {
    logic       st, sp, os;
    logic [7:0] per;
    int         n;
    logic       e_busy;
    logic [7:0] e_rem;
    int         e_dones;
  } vec_t;

  vec_t vt[11];

  initial begin
    int pre_cnt, done_cyc, done_cnt;
    vt[0]  = '{1, 0, 1, 8'd3,   30, 1, 8'd1,   1};
    vt[1]  = '{0, 0, 0, 8'd0,    1, 0, 8'd0,   0};
    vt[2]  = '{1, 0, 1, 8'd0,    3, 0, 8'd0,   0};
    vt[3]  = '{1, 0, 0, 8'd2,   41, 1, 8'd2,   2};
    vt[4]  = '{0, 1, 0, 8'd0,    0, 1, 8'd2,   0};
    vt[5]  = '{0, 0, 0, 8'd0,    0, 0, 8'd0,   0};
    vt[6]  = '{1, 0, 1, 8'd1,   10, 1, 8'd1,   1};
    vt[7]  = '{1, 0, 1, 8'd255,  0, 0, 8'd0,   0};
    vt[8]  = '{0, 0, 0, 8'd0,    5, 1, 8'd255, 0};
    vt[9]  = '{1, 1, 0, 8'd4,    0, 1, 8'd255, 0};
    vt[10] = '{0, 0, 0, 8'd0,    0, 0, 8'd0,   0};

    reset = 1'b1; start = 0; stop = 0; oneshot = 0; period = '0; pause = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pre", 32'(pre_tick), 0);
    chk("reset_done", 32'(done_tick), 0);
    chk("reset_rem", 32'(remaining), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      dones_seen = 0;
      cycle(vt[v].st, vt[v].sp, vt[v].os, vt[v].per, 1'b0);
      idle_cycles(vt[v].n);
      chk($sformatf("vec%0d_busy", v), 32'(last_busy), 32'(vt[v].e_busy));
      chk($sformatf("vec%0d_rem", v), 32'(last_rem), 32'(vt[v].e_rem));
      chk($sformatf("vec%0d_dones", v), 32'(dones_seen), 32'(vt[v].e_dones));
    end

    // Stop mid-interval: no expiry, idle next cycle
    dones_seen = 0;
    cycle(1, 0, 1, 8'd5, 0);
    idle_cycles(14);
    cycle(0, 1, 0, 8'd0, 0);
    idle_cycles(1);
    chk("stop15_busy", 32'(last_busy), 0);
    chk("stop15_rem", 32'(last_rem), 0);
    chk("stop15_dones", 32'(dones_seen), 0);

    // Stop coincident with periodic expiry: strobe still visible, then idle
    cycle(1, 0, 0, 8'd1, 0);
    idle_cycles(9);
    cycle(0, 1, 0, 8'd0, 0);
    chk("stop_on_done", 32'(last_done), 1);
    idle_cycles(1);
    chk("stop_on_done_idle", 32'(last_busy), 0);

    // Restart at cycle 12 with period 4: single expiry at cycle 52
    cycle(1, 0, 1, 8'd3, 0);
    done_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 55; k++) begin
      if (k == 12) cycle(1, 0, 1, 8'd4, 0);
      else cycle(0, 0, 0, 8'd0, 0);
      if (last_done === 1'b1) begin done_cnt++; done_cyc = k; end
    end
    chk("restart_done_cnt", 32'(done_cnt), 1);
    chk("restart_done_cyc", 32'(done_cyc), 52);

    // Asynchronous reset at cycle 17, checked before any further clock edge
    cycle(1, 0, 1, 8'd3, 0);
    idle_cycles(16);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_rem", 32'(remaining), 0);
    chk("async_done", 32'(done_tick), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Basic one-shot after reset
    cycle(1, 0, 1, 8'd3, 0);
    pre_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 31; k++) begin
      cycle(0, 0, 0, 8'd0, 0);
      if (last_pre === 1'b1) pre_cnt++;
      if (last_done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (k == 31) chk("oneshot_busy31", 32'(last_busy), 0);
    end
    chk("oneshot_pre_cnt", 32'(pre_cnt), 3);
    chk("oneshot_done_cnt", 32'(done_cnt), 1);
    chk("oneshot_done_cyc", 32'(done_cyc), 30);

`ifdef TICK_TIMER_CTRL_PAUSE_EN
    // Pause cycles 5-14 delays the period-2 expiry from 20 to 30
    cycle(1, 0, 1, 8'd2, 0);
    done_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 31; k++) begin
      cycle(0, 0, 0, 8'd0, (k >= 5 && k <= 14));
      if (last_done === 1'b1) begin done_cnt++; done_cyc = k; end
    end
    chk("pause_done_cnt", 32'(done_cnt), 1);
    chk("pause_done_cyc", 32'(done_cyc), 30);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic s, sp, os, pa;
      logic [7:0] per;
      s   = ($urandom_range(0, 29) == 0);
      sp  = ($urandom_range(0, 59) == 0);
      os  = 1'($urandom_range(0, 1));
      pa  = ($urandom_range(0, 7) == 0);
      per = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(0, 4));
      cycle(s, sp, os, per, pa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer_ctrl.md
TICK_TIMER_CTRL -- requirements
Module: tick_timer_ctrl

Interface
REQ-001 Parameter M, default 10, prescaler modulus in clk cycles per pre_tick; legal M >= 2.
REQ-002 Parameter W, default 8, width of period and remaining-count registers; legal W >= 1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level-sampled each cycle; load period and (re)start timing.
REQ-006 stop  input  1  abort timing, return to idle.
REQ-007 oneshot  input  1  mode sampled with start: 1 = single expiry, 0 = periodic.
REQ-008 period  input  W  number of pre_ticks per expiry, sampled with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 pre_tick  output  1  one-cycle prescaler wrap strobe, RUN only.
REQ-011 done_tick  output  1  one-cycle expiry strobe.
REQ-012 remaining  output  W  pre_ticks left in current interval.

Function
REQ-013 Two states SHALL exist: IDLE and RUN; busy SHALL equal (state==RUN).
REQ-014 Prescaler SHALL be ceil(log2(M)) bits (minimum 1), count 0..M-1 then wrap to 0 in RUN, and be held at 0 in IDLE.
REQ-015 pre_tick SHALL be combinational: RUN and prescaler==M-1 (gated per REQ-030).
REQ-016 IDLE, start=1, period!=0: next state RUN; period latched to per_reg, oneshot latched to mode_reg, remaining<=period, prescaler<=0.
REQ-017 IDLE, start=1, period==0: request ignored; stay IDLE, no done_tick, remaining stays 0.
REQ-018 RUN, pre_tick and remaining>1: remaining decrements by 1.
REQ-019 done_tick SHALL be combinational: pre_tick and remaining==1.
REQ-020 On done_tick with mode_reg=1: next state IDLE, remaining<=0.
REQ-021 On done_tick with mode_reg=0: stay RUN, remaining<=per_reg; no idle gap between intervals.
REQ-022 Timing: counting the first cycle after the edge sampling start as cycle 1, done_tick SHALL be high in cycle M*P only (P = latched period); periodic mode repeats every M*P cycles.
REQ-023 RUN, stop=1: next state IDLE, remaining<=0, prescaler<=0; done_tick still visible that cycle if REQ-019 holds, but no reload occurs.
REQ-024 RUN, start=1 (stop=0) with period!=0: restart per REQ-016 semantics, discarding current interval; done_tick of that cycle still asserted if REQ-019 holds.
REQ-025 RUN, start=1 with period==0 (stop=0): treated as stop.
REQ-026 Priority when simultaneous: stop > start > expiry/reload.
REQ-027 Changes on period/oneshot while RUN without start SHALL have no effect.

Reset
REQ-028 reset=1 SHALL force state IDLE, prescaler 0, remaining 0, per_reg 0, mode_reg 0 immediately, regardless of clk.
REQ-029 During and after reset until a valid start: busy=0, pre_tick=0, done_tick=0, remaining=0; reset mid-RUN SHALL produce no done_tick.

Configuration
REQ-030 Macro TICK_TIMER_CTRL_PAUSE_EN defined: extra input port pause (1 bit); in RUN with pause=1, prescaler and remaining hold, pre_tick and done_tick forced 0, busy stays 1; stop/start still honored with unchanged priority.
REQ-031 Macro undefined: no pause port; behaviour identical to pause tied 0.

Verification
REQ-032 M=10, period=3, oneshot=1, one-cycle start: pre_tick at cycles 10,20,30; done_tick only at cycle 30; busy 0 from cycle 31; remaining 3,2,1,0.
REQ-033 M=10, period=2, oneshot=0: done_tick at cycles 20,40,60; busy never drops; remaining reloads to 2 at cycles 21,41.
REQ-034 M=10, period=5, stop at cycle 15 -> busy 0 at cycle 16, remaining 0, no done_tick ever; stop coincident with done_tick in periodic mode -> done_tick seen, then IDLE.
REQ-035 start with period=0 in IDLE -> busy stays 0; start with period=4 at cycle 12 of period=3 run -> new done_tick at cycle 12+40, none at 30.
REQ-036 reset asserted asynchronously at cycle 17 of period=3 run -> busy, remaining 0 without clk edge; no done_tick; subsequent start behaves per REQ-032.
REQ-037 With TICK_TIMER_CTRL_PAUSE_EN, period=2, pause high cycles 5-14 -> done_tick at cycle 30; without macro, compile succeeds with no pause port and REQ-032 passes.
